// File: rtl/tx_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package tx_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_e;

  localparam int         BLOCK_BYTES  = 16;
  localparam int         BLOCK_W      = 128;
  localparam logic [7:0] HDR_BASE_DEF = 8'hA0;

  // Width of a source index; a 1-bit index is still needed when N == 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester above `last`, wrapping to 0.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] grant_idx,
  output logic          any
);
  int idx;

  // Scan from farthest to nearest so the nearest requester after `last` wins.
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (req[idx]) begin
        grant_idx = IW'(idx);
        any       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tx_arbiter.sv
// Round-robin serializer of 128-bit blocks onto a byte-wide UART handshake.
module tx_arbiter
  import tx_pkg::*;
#(
  parameter int         NUM_REQ   = 2,
  parameter int         HEADER_EN = 1,
  parameter logic [7:0] HDR_BASE  = HDR_BASE_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*BLOCK_W-1:0] din,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [7:0]                 dout,
  output logic                       tx_start,
  input  logic                       tx_done
);
  localparam int IW = idx_w(NUM_REQ);

  state_e               state_q, state_d;
  logic [IW-1:0]        src_q, src_d, last_q, last_d, gnt;
  logic [BLOCK_W-1:0]   data_q, data_d, blk;
  logic [4:0]           cnt_q, cnt_d;
  logic [7:0]           dout_q, dout_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d, done_q, done_d;
  logic                 any;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req      (req),
    .last     (last_q),
    .grant_idx(gnt),
    .any      (any)
  );

  assign ack      = ack_q;
  assign done     = done_q;
  assign dout     = dout_q;
  assign busy     = (state_q != IDLE);
  assign tx_start = (state_q == SEND);

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      data_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= 8'h00;
      ack_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      last_q  <= last_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. The byte for each SEND is staged into dout on the edge
  // entering SEND, so tx_start and a valid dout appear in the same cycle.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    last_d  = last_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    ack_d   = '0;
    done_d  = '0;
    blk     = din[int'(src_q)*BLOCK_W +: BLOCK_W];
    case (state_q)
      IDLE: begin
        if (any) begin
          src_d      = gnt;
          ack_d[gnt] = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        last_d  = src_q;
        state_d = SEND;
        if (HEADER_EN != 0) begin
          cnt_d  = 5'd0;
          dout_d = HDR_BASE | {{(8-IW){1'b0}}, src_q};
          data_d = blk;
        end else begin
          cnt_d  = 5'd1;
          dout_d = blk[BLOCK_W-1 -: 8];
          data_d = blk << 8;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (cnt_q == 5'(BLOCK_BYTES)) begin
            done_d[src_q] = 1'b1;
            state_d       = IDLE;
          end else begin
            cnt_d   = cnt_q + 5'd1;
            dout_d  = data_q[BLOCK_W-1 -: 8];
            data_d  = data_q << 8;
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench: 2-source header config (A) and 4-source headerless config (B).
module tb_tx_arbiter;
  logic         clk = 1'b0;
  logic         reset_a, reset_b;
  logic [1:0]   req_a;
  logic [3:0]   req_b;
  logic [255:0] din_a;
  logic [511:0] din_b;
  logic [1:0]   ack_a, done_a;
  logic [3:0]   ack_b, done_b;
  logic         busy_a, busy_b, tx_start_a, tx_start_b, tx_done_a, tx_done_b;
  logic [7:0]   dout_a, dout_b;

  int tests = 0, fails = 0;
  int starts_a = 0, starts_b = 0;

  localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_B = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] BLK_C = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;

  tx_arbiter #(.NUM_REQ(2), .HEADER_EN(1), .HDR_BASE(8'hA0)) dut_a (
    .clk(clk), .reset(reset_a), .req(req_a), .din(din_a), .ack(ack_a), .done(done_a),
    .busy(busy_a), .dout(dout_a), .tx_start(tx_start_a), .tx_done(tx_done_a));

  tx_arbiter #(.NUM_REQ(4), .HEADER_EN(0), .HDR_BASE(8'hA0)) dut_b (
    .clk(clk), .reset(reset_b), .req(req_b), .din(din_b), .ack(ack_b), .done(done_b),
    .busy(busy_b), .dout(dout_b), .tx_start(tx_start_b), .tx_done(tx_done_b));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_start_a) starts_a++;
    if (tx_start_b) starts_b++;
  end

  typedef struct {
    logic [1:0] req;
    int         src;
    logic [7:0] tag;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One frame on DUT A acting as the UART: tx_done 10 cycles after each tx_start.
  task automatic frame_a(input int src, input logic [7:0] tag, input bit drop_on_ack,
                         input bit spur, input int rst_at, input int r1_on, input int r1_off);
    logic [127:0] blk;
    logic [1:0]   oh;
    logic [7:0]   eb;
    bit           got;
    int           s0;
    blk = (src == 1) ? BLK_B : BLK_A;
    oh  = 2'b01 << src;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (ack_a != 2'b00) got = 1'b1;
    end
    chk("ack_a", ack_a, oh);
    if (!got) return;
    if (drop_on_ack) req_a = 2'b00;
    s0 = starts_a;
    for (int b = 0; b < 17; b++) begin
      if (b == r1_on)  req_a[1] = 1'b1;
      if (b == r1_off) req_a[1] = 1'b0;
      got = tx_start_a;
      for (int i = 0; i < 40 && !got; i++) begin
        tick();
        if (tx_start_a) got = 1'b1;
      end
      if (!got) begin
        chk("tx_start_a timeout", 0, 1);
        return;
      end
      eb = (b == 0) ? tag : blk[(127 - 8*(b-1)) -: 8];
      chk($sformatf("byte_a[%0d]", b), dout_a, eb);
      if (b == rst_at) begin
        reset_a = 1'b1;
        tick();
        chk("rst outputs", {ack_a, done_a, busy_a, tx_start_a, dout_a}, 0);
        reset_a = 1'b0;
        return;
      end
      if (spur) tx_done_a = 1'b1;
      repeat (10) begin
        tick();
        tx_done_a = 1'b0;
      end
      tx_done_a = 1'b1;
      tick();
      tx_done_a = 1'b0;
    end
    chk("done_a", done_a, oh);
    chk("busy_a at done", busy_a, 0);
    chk("starts per frame", starts_a - s0, 17);
  endtask

  vec_t vecs[6];

  initial begin
    int  s0;
    bit  bad;
    vecs[0] = '{2'b11, 0, 8'hA0};
    vecs[1] = '{2'b11, 1, 8'hA1};
    vecs[2] = '{2'b11, 0, 8'hA0};
    vecs[3] = '{2'b11, 1, 8'hA1};
    vecs[4] = '{2'b10, 1, 8'hA1};
    vecs[5] = '{2'b01, 0, 8'hA0};

    reset_a = 1'b1; reset_b = 1'b1;
    req_a = '0; req_b = '0; tx_done_a = 1'b0; tx_done_b = 1'b0;
    din_a = {BLK_B, BLK_A};
    din_b = {BLK_C, 128'h3, 128'h2, 128'h1};
    repeat (3) tick();
    chk("reset A outputs", {ack_a, done_a, busy_a, tx_start_a, dout_a}, 0);
    chk("reset B outputs", {ack_b, done_b, busy_b, tx_start_b, dout_b}, 0);
    reset_a = 1'b0; reset_b = 1'b0;
    tick();

    // Single source with header.
    req_a = 2'b01;
    frame_a(0, 8'hA0, 1, 0, -1, -1, -1);

    // Spurious tx_done in IDLE, then on every tx_start cycle of a frame.
    s0 = starts_a;
    tx_done_a = 1'b1; tick(); tx_done_a = 1'b0; tick();
    chk("idle spurious starts", starts_a - s0, 0);
    chk("idle spurious busy", busy_a, 0);
    req_a = 2'b01;
    frame_a(0, 8'hA0, 1, 1, -1, -1, -1);

    // req[1] raised mid-frame and dropped before the frame ends.
    tick();
    req_a = 2'b01;
    frame_a(0, 8'hA0, 1, 0, -1, 5, 10);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack_a != 2'b00 || busy_a) bad = 1'b1;
    end
    chk("dropped req stays idle", bad, 0);

    // Contention table from reset.
    reset_a = 1'b1; tick(); reset_a = 1'b0;
    foreach (vecs[i]) begin
      req_a = vecs[i].req;
      frame_a(vecs[i].src, vecs[i].tag, 0, 0, -1, -1, -1);
    end
    req_a = 2'b00;
    tick(); tick();

    // Reset mid-frame at byte 8.
    req_a = 2'b01;
    frame_a(0, 8'hA0, 1, 0, 8, -1, -1);
    s0  = starts_a;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done_a != 2'b00 || busy_a) bad = 1'b1;
    end
    chk("no done after reset", bad, 0);
    chk("no starts after reset", starts_a - s0, 0);
    req_a = 2'b10;
    frame_a(1, 8'hA1, 1, 0, -1, -1, -1);
    reset_a = 1'b1; tick(); reset_a = 1'b0;
    req_a = 2'b11;
    frame_a(0, 8'hA0, 1, 0, -1, -1, -1);

    // Headerless, 4 sources, only source 3.
    begin
      bit got;
      req_b = 4'b1000;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        tick();
        if (ack_b != 4'b0000) got = 1'b1;
      end
      chk("ack_b", ack_b, 4'b1000);
      req_b = 4'b0000;
      s0 = starts_b;
      for (int b = 0; b < 16 && got; b++) begin
        got = tx_start_b;
        for (int i = 0; i < 40 && !got; i++) begin
          tick();
          if (tx_start_b) got = 1'b1;
        end
        if (!got) chk("tx_start_b timeout", 0, 1);
        else begin
          chk($sformatf("byte_b[%0d]", b), dout_b, BLK_C[(127 - 8*b) -: 8]);
          repeat (3) tick();
          tx_done_b = 1'b1;
          tick();
          tx_done_b = 1'b0;
        end
      end
      chk("done_b", done_b, 4'b1000);
      chk("busy_b at done", busy_b, 0);
      chk("starts_b per frame", starts_b - s0, 16);
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Shares the single byte-wide UART transmit path between `NUM_REQ` requesters, each presenting a 128-bit block (ciphertext, status word, debug capture). It picks one requester round-robin, latches its block, and sends an optional source-tag header byte followed by the 16 block bytes, MSB byte first. Each byte uses the UART `tx_start`/`tx_done` handshake. It sits between the AES core/status logic and the UART transmitter and replaces per-source serializers.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..16.
- `HEADER_EN`, 1: 1 prepends a tag byte; 0 sends the 16 data bytes only.
- `HDR_BASE`, 8'hA0: tag byte is `HDR_BASE | src`. Low 4 bits of `HDR_BASE` must be 0.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  NUM_REQ  level request per source; held until `ack`.
- `din`  in  NUM_REQ*128  source i block at `din[i*128 +: 128]`.
- `ack`  out  NUM_REQ  one-cycle pulse: source's block latched; source may drop `req` and change `din`.
- `done`  out  NUM_REQ  one-cycle pulse: last byte of source's frame acknowledged by UART.
- `busy`  out  1  high in every state except IDLE.
- `dout`  out  8  byte to UART; valid with `tx_start`, held until the next `tx_start`.
- `tx_start`  out  1  one-cycle pulse requesting transmission of `dout`.
- `tx_done`  in  1  one-cycle pulse from UART: current byte finished.

## Operation
- States: IDLE, LOAD, SEND, WAIT.
- IDLE: if any `req` is set, the arbiter selects `src` round-robin, searching upward from `last+1` with wrap to 0. Go to LOAD. With no request, stay in IDLE.
- LOAD:
  - `data <= din[src]`, pulse `ack[src]`, `last <= src`.
  - `cnt <= 0` if `HEADER_EN`, else `cnt <= 1`.
  - Go to SEND.
- SEND:
  - `dout <=` tag when `cnt == 0`; otherwise `data[127:120]`, then `data <<= 8`.
  - Pulse `tx_start`. Go to WAIT.
- WAIT: on `tx_done`:
  - If `cnt == 16`, pulse `done[src]` and go to IDLE.
  - Otherwise `cnt <= cnt + 1` and go to SEND.
- `cnt` is 5 bits, range 0..16. Frame length is 17 bytes with header, 16 without.
- `req` is sampled only in IDLE. A request arriving mid-frame waits; a request dropped before grant is lost without `ack`.
- `tx_done` is ignored outside WAIT, including the same cycle as `tx_start`.
- Round-robin fairness: with all sources requesting continuously, grants rotate 0,1,..,NUM_REQ-1,0.

## Timing
- Reset values:
  - Outputs: `ack = 0`, `done = 0`, `busy = 0`, `tx_start = 0`, `dout = 8'h00`.
  - Internal: state IDLE, `last = NUM_REQ-1` so source 0 wins first, `data = 0`, `cnt = 0`.
- Reset asserted mid-frame aborts the frame next edge. No `done` is issued and no further `tx_start` is sent.
- `req` seen in IDLE at edge N gives: LOAD and `ack` during cycle N+1, and the first `tx_start` (header) during cycle N+2.
- `tx_done` at edge M gives the next `tx_start` during cycle M+1, i.e. one cycle of gap per byte.
- `done` is asserted during the cycle after the final `tx_done`; `busy` falls in the same cycle.
- After a frame, at least one IDLE cycle separates the frame from the next grant.
- Back-to-back `tx_done` pulses with no intervening SEND cannot occur under the UART contract. Any extra pulse outside WAIT is ignored.

## Structure
- Package `tx_pkg`: state enum (IDLE, LOAD, SEND, WAIT), `BLOCK_BYTES = 16`, `BLOCK_W = 128`, default `HDR_BASE`.
- Sub-module `rr_arbiter` (parameter `N`): inputs `req`, `last`; outputs `grant_idx`, `any`. Purely combinational priority rotate, used in IDLE.
- The top level holds the FSM, 128-bit shift register, byte counter and `last` pointer.

## Test plan
- Single source: `req[0]` with `din0 = 128'h00112233_44556677_8899AABB_CCDDEEFF`, UART `tx_done` 10 cycles after each `tx_start`. Required: bytes A0,00,11,..,FF (17 `tx_start`), `ack[0]` on cycle 2, one `done[0]`.
- Contention: `req = 2'b11` from reset, both held. Required: frames granted 0,1,0,1; tags A0,A1,A0,A1.
- `HEADER_EN = 0`, `NUM_REQ = 4`, only `req[3]`. Required: 16 bytes exactly, no tag, `done[3]` after the 16th `tx_done`.
- Spurious `tx_done` in IDLE and on the same cycle as `tx_start`. Required: no change in byte count; the frame still sends 17 bytes.
- Reset at byte 8 of a frame. Required: next cycle all outputs 0; no `done`. Then `req[1]` gives the first grant to source 1, and source 0 wins if both request.
- `req[1]` raised mid-frame of source 0, then dropped before frame end. Required: no `ack[1]`, IDLE persists.
